// File: rtl/rom_scan_reader.sv
// Reads a 556PT5/556PT4 PROM one address at a time, double-sampling each word
// after a settle delay and presenting it with its address on a valid/ready stream.
module rom_scan_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int MAX_ADDRESS = 511,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [3:0] OPERATION_READ = 4'b0011,
  parameter int ERROR_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         increment_address,
  input  logic                         decrement_address,
  input  logic [DATA_WIDTH-1:0]        data_line_in,
  output logic [3:0]                   operation,
  output logic [ADDRESS_WIDTH-1:0]     address_line,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [ADDRESS_WIDTH-1:0]     data_address,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         mismatch,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count,
  output logic                         busy,
  output logic                         done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETTLE   = 3'd1;
  localparam logic [2:0] SAMPLE_A = 3'd2;
  localparam logic [2:0] SAMPLE_B = 3'd3;
  localparam logic [2:0] PRESENT  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(MAX_ADDRESS);

  logic [2:0]            state_reg;
  logic [CW-1:0]         settle_count_reg;
  logic [DATA_WIDTH-1:0] sample_a_reg;
  logic                  prev_inc_reg;
  logic                  prev_dec_reg;
  logic                  mode_reg;

  // Simultaneous presses cancel each other so a bouncing pair never steps.
  logic inc_edge;
  logic dec_edge;
  assign inc_edge = increment_address & ~prev_inc_reg & ~decrement_address;
  assign dec_edge = decrement_address & ~prev_dec_reg & ~increment_address;

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      operation        <= 4'b0000;
      address_line     <= '0;
      data_out         <= '0;
      data_address     <= '0;
      data_valid       <= 1'b0;
      mismatch         <= 1'b0;
      error_count      <= '0;
      done             <= 1'b0;
      state_reg        <= IDLE;
      settle_count_reg <= '0;
      sample_a_reg     <= '0;
      prev_inc_reg     <= 1'b0;
      prev_dec_reg     <= 1'b0;
      mode_reg         <= 1'b0;
    end else begin
      operation    <= OPERATION_READ;
      prev_inc_reg <= increment_address;
      prev_dec_reg <= decrement_address;
      done         <= 1'b0;
      if (abort && state_reg != IDLE) begin
        state_reg  <= IDLE;
        data_valid <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            settle_count_reg <= '0;
            mode_reg         <= mode;
            if (mode && start) begin
              address_line <= '0;
              state_reg    <= SETTLE;
            end else if (!mode && inc_edge) begin
              address_line <= (address_line == ADDR_MAX) ? '0 : address_line + 1'b1;
              state_reg    <= SETTLE;
            end else if (!mode && dec_edge) begin
              address_line <= (address_line == '0) ? ADDR_MAX : address_line - 1'b1;
              state_reg    <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_count_reg == SETTLE_LAST) begin
              state_reg <= SAMPLE_A;
            end else begin
              settle_count_reg <= settle_count_reg + 1'b1;
            end
          end
          SAMPLE_A: begin
            sample_a_reg <= data_line_in;
            state_reg    <= SAMPLE_B;
          end
          SAMPLE_B: begin
            data_out     <= sample_a_reg;
            data_address <= address_line;
            mismatch     <= (data_line_in != sample_a_reg);
            if (data_line_in != sample_a_reg && error_count != '1) begin
              error_count <= error_count + 1'b1;
            end
            data_valid <= 1'b1;
            state_reg  <= PRESENT;
          end
          PRESENT: begin
            if (data_ready) begin
              data_valid <= 1'b0;
              if (!mode_reg) begin
                state_reg <= IDLE;
              end else if (address_line == ADDR_MAX) begin
                done      <= 1'b1;
                state_reg <= DONE;
              end else begin
                address_line     <= address_line + 1'b1;
                settle_count_reg <= '0;
                state_reg        <= SETTLE;
              end
            end
          end
          DONE: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Randomised bench for rom_scan_reader: chip model, stream scoreboard and a
// second instance in the 3601 (4x256) configuration.
module tb_rom_scan_reader;

  localparam int SETTLE = 4;
  localparam int MAXA = 511;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3604 instance
  logic       reset, mode, start, abort, inc, dec, data_ready;
  logic [7:0] data_line_in, data_out;
  logic [3:0] operation;
  logic [8:0] address_line, data_address;
  logic       data_valid, mismatch, busy, done;
  logic [15:0] error_count;

  // 3601 instance
  logic       reset_s, mode_s, start_s, abort_s, inc_s, dec_s, data_ready_s;
  logic [3:0] data_line_in_s, data_out_s, operation_s;
  logic [7:0] address_line_s, data_address_s;
  logic       data_valid_s, mismatch_s, busy_s, done_s;
  logic [15:0] error_count_s;

  rom_scan_reader dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .abort(abort),
    .increment_address(inc), .decrement_address(dec), .data_line_in(data_line_in),
    .operation(operation), .address_line(address_line), .data_out(data_out),
    .data_address(data_address), .data_valid(data_valid), .data_ready(data_ready),
    .mismatch(mismatch), .error_count(error_count), .busy(busy), .done(done)
  );

  rom_scan_reader #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .MAX_ADDRESS(255)) dut_s (
    .clk(clk), .reset(reset_s), .mode(mode_s), .start(start_s), .abort(abort_s),
    .increment_address(inc_s), .decrement_address(dec_s), .data_line_in(data_line_in_s),
    .operation(operation_s), .address_line(address_line_s), .data_out(data_out_s),
    .data_address(data_address_s), .data_valid(data_valid_s), .data_ready(data_ready_s),
    .mismatch(mismatch_s), .error_count(error_count_s), .busy(busy_s), .done(done_s)
  );

  int checks = 0;
  int failures = 0;
  int model_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] chip_word(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ 8'hA5;
  endfunction

  // Chip model: optionally corrupts the word at address 7 during the second sample.
  bit         glitch_en = 0;
  int         cyc_since = 0;
  logic [8:0] last_addr;
  logic [7:0] glitch_mask = 8'h00;
  always @(negedge clk) begin
    if (address_line != last_addr) cyc_since = 0;
    else cyc_since++;
    last_addr = address_line;
    glitch_mask = (glitch_en && address_line == 9'd7 && cyc_since == SETTLE + 1) ? 8'hFF : 8'h00;
  end
  assign data_line_in   = chip_word(int'(address_line)) ^ glitch_mask;
  assign data_line_in_s = address_line_s[3:0] ^ 4'h5;

  task automatic manual_step(input bit up, input int exp_addr);
    int n;
    @(negedge clk);
    mode = 0; data_ready = 1;
    if (up) inc = 1; else dec = 1;
    @(negedge clk);
    inc = 0; dec = 0;
    check("man_addr", address_line, exp_addr);
    n = 0;
    while (!data_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("man_latency", n, SETTLE + 2);
    check("man_data_addr", data_address, exp_addr);
    check("man_data", data_out, chip_word(exp_addr));
    check("man_mismatch", mismatch, 0);
    @(negedge clk);
    check("man_idle", busy, 0);
    check("man_valid_low", data_valid, 0);
  endtask

  task automatic run_dump(input bit rand_ready, input int abort_at, input int glitch_addr);
    int n, dones, cyc;
    bit stall;
    logic [7:0] held_d;
    logic [8:0] held_a;
    logic held_m;
    n = 0; dones = 0; stall = 0;
    held_d = '0; held_a = '0; held_m = 0;
    @(negedge clk);
    mode = 1; start = 1; inc = 0; dec = 0;
    @(negedge clk);
    start = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      if (dones > 0 && !busy) break;
      if (abort_at >= 0 && busy && address_line == abort_at && n == abort_at) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", data_valid, 0);
        check("abort_addr", address_line, abort_at);
        check("abort_done", done, 0);
        check("abort_words", n, abort_at);
        @(negedge clk);
        check("abort_stays_idle", busy, 0);
        return;
      end
      data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rand_ready) begin
        mode  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        inc   = 1'($urandom_range(0, 1));
        dec   = 1'($urandom_range(0, 1));
      end
      if (stall) begin
        check("stall_valid", data_valid, 1);
        check("stall_data", data_out, held_d);
        check("stall_addr", data_address, held_a);
        check("stall_mismatch", mismatch, held_m);
      end
      stall = 0;
      if (data_valid) begin
        if (data_ready) begin
          check("word_addr", data_address, n);
          check("word_data", data_out, chip_word(n));
          check("word_mismatch", mismatch, (n == glitch_addr));
          if (n == glitch_addr) model_errors++;
          n++;
        end else begin
          stall = 1;
          held_d = data_out; held_a = data_address; held_m = mismatch;
        end
      end
      if (done) dones++;
      @(negedge clk);
    end
    mode = 1; start = 0; inc = 0; dec = 0; data_ready = 1;
    check("dump_in_time", (cyc < 20000), 1);
    check("dump_words", n, MAXA + 1);
    check("dump_done_pulses", dones, 1);
    check("dump_idle", busy, 0);
    check("dump_final_addr", address_line, MAXA);
    check("dump_errors", error_count, model_errors);
  endtask

  initial begin
    int n, dones, cyc;
    logic [7:0] tmp;
    reset = 1; mode = 0; start = 0; abort = 0; inc = 0; dec = 0; data_ready = 1;
    reset_s = 1; mode_s = 0; start_s = 0; abort_s = 0; inc_s = 0; dec_s = 0; data_ready_s = 1;
    repeat (3) @(negedge clk);
    check("rst_operation", operation, 0);
    check("rst_address", address_line, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_address", data_address, 0);
    check("rst_valid", data_valid, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_errors", error_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 0;
    @(negedge clk);
    check("op_read", operation, 4'b0011);

    // Idle-time inputs that must not start anything.
    abort = 1; @(negedge clk); abort = 0;
    check("abort_in_idle", busy, 0);
    inc = 1; dec = 1; @(negedge clk); inc = 0; dec = 0;
    check("both_buttons", busy, 0);
    mode = 1; inc = 1; @(negedge clk); inc = 0;
    check("buttons_in_auto", busy, 0);
    mode = 0; start = 1; @(negedge clk); start = 0;
    check("start_in_manual", busy, 0);
    check("idle_addr_kept", address_line, 0);

    manual_step(1, 1);
    manual_step(0, 0);
    manual_step(0, MAXA);
    manual_step(1, 0);

    run_dump(0, -1, -1);
    run_dump(1, -1, -1);
    glitch_en = 1;
    run_dump(0, -1, 7);
    glitch_en = 0;
    run_dump(0, 100, -1);
    run_dump(1, -1, -1);

    // 3601 configuration
    @(negedge clk);
    reset_s = 0;
    @(negedge clk);
    mode_s = 1; start_s = 1;
    @(negedge clk);
    start_s = 0;
    n = 0; dones = 0;
    for (cyc = 0; cyc < 10000; cyc++) begin
      if (dones > 0 && !busy_s) break;
      if (data_valid_s) begin
        tmp = n[7:0] ^ 8'hA5;
        check("s_word_addr", data_address_s, n);
        check("s_word_data", data_out_s, tmp[3:0]);
        n++;
      end
      if (done_s) dones++;
      @(negedge clk);
    end
    check("s_in_time", (cyc < 10000), 1);
    check("s_words", n, 256);
    check("s_done_pulses", dones, 1);
    check("s_final_addr", address_line_s, 255);
    mode_s = 0; inc_s = 1;
    @(negedge clk);
    inc_s = 0;
    check("s_inc_wrap", address_line_s, 0);
    cyc = 0;
    while (busy_s && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("s_manual_idle", busy_s, 0);
    mode_s = 1; start_s = 1;
    @(negedge clk);
    start_s = 0;
    cyc = 0;
    while (address_line_s != 8'd50 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("s_reached_50", address_line_s, 50);
    reset_s = 1;
    @(negedge clk);
    check("s_rst_operation", operation_s, 0);
    check("s_rst_address", address_line_s, 0);
    check("s_rst_data_out", data_out_s, 0);
    check("s_rst_data_address", data_address_s, 0);
    check("s_rst_valid", data_valid_s, 0);
    check("s_rst_mismatch", mismatch_s, 0);
    check("s_rst_errors", error_count_s, 0);
    check("s_rst_busy", busy_s, 0);
    check("s_rst_done", done_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
